// File: rtl/btb_2way_sat.sv
// Branch target buffer: 2-way set-associative, per-set LRU, saturating taken counters.
// Fetch lookup is combinational; execute-stage updates commit on the falling clock edge.
module btb_2way_sat #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCE,
  input  logic        BrInstE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  output logic        HitF,
  output logic        PredictF,
  output logic [31:0] PredictTarget,
  output logic        HitE
);
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1 << (CNT_BITS - 1));

  logic                valid_q  [2][SETS];
  logic [TAG_BITS-1:0] tag_q    [2][SETS];
  logic [31:0]         target_q [2][SETS];
  logic [CNT_BITS-1:0] cnt_q    [2][SETS];
  logic [SETS-1:0]     lru_q;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic [1:0]            way_hit_f, way_hit_e;
  logic                  hit_way_f, hit_way_e, victim;
  logic                  unused_pc_bits;

  // Byte offset within the instruction word takes no part in index or tag.
  assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

  assign idx_f = PCF[INDEX_BITS+1:2];
  assign tag_f = PCF[31:INDEX_BITS+2];
  assign idx_e = PCE[INDEX_BITS+1:2];
  assign tag_e = PCE[31:INDEX_BITS+2];

  always_comb begin
    way_hit_f = '0;
    way_hit_e = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit_f[w] = valid_q[w][idx_f] && (tag_q[w][idx_f] == tag_f);
      way_hit_e[w] = valid_q[w][idx_e] && (tag_q[w][idx_e] == tag_e);
    end
  end

  // Way 0 wins if both ways were ever to match.
  assign hit_way_f = ~way_hit_f[0];
  assign hit_way_e = ~way_hit_e[0];

  assign HitF          = |way_hit_f;
  assign PredictF      = HitF && cnt_q[hit_way_f][idx_f][CNT_BITS-1];
  assign PredictTarget = HitF ? target_q[hit_way_f][idx_f] : 32'h0;
  assign HitE          = |way_hit_e;

  always_comb begin
    if (!valid_q[0][idx_e])      victim = 1'b0;
    else if (!valid_q[1][idx_e]) victim = 1'b1;
    else                         victim = lru_q[idx_e];
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          valid_q[w][s]  <= 1'b0;
          tag_q[w][s]    <= '0;
          target_q[w][s] <= '0;
          cnt_q[w][s]    <= '0;
        end
      end
    end else if (BrInstE) begin
      if (HitE) begin
        cnt_q[hit_way_e][idx_e] <= BranchE ? sat_inc(cnt_q[hit_way_e][idx_e])
                                           : sat_dec(cnt_q[hit_way_e][idx_e]);
        if (BranchE) target_q[hit_way_e][idx_e] <= BranchTarget;
        lru_q[idx_e] <= ~hit_way_e;
      end else if (BranchE) begin
        // Allocate into the victim way as weakly taken.
        valid_q[victim][idx_e]  <= 1'b1;
        tag_q[victim][idx_e]    <= tag_e;
        target_q[victim][idx_e] <= BranchTarget;
        cnt_q[victim][idx_e]    <= CNT_INIT;
        lru_q[idx_e]            <= ~victim;
      end
    end
  end
endmodule

// File: tb/tb_btb_2way_sat.sv
// Randomised and directed bench for btb_2way_sat against a per-set recency-list model.
module tb_btb_2way_sat;
  localparam int IB    = 4;
  localparam int CB    = 2;
  localparam int SETS  = 1 << IB;
  localparam int CMAX  = (1 << CB) - 1;
  localparam int CINIT = 1 << (CB - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = '0, PCE = '0, BranchTarget = '0;
  logic        BrInstE = 1'b0, BranchE = 1'b0;
  logic        HitF, PredictF, HitE;
  logic [31:0] PredictTarget;

  int errors = 0;
  int checks = 0;

  btb_2way_sat #(.INDEX_BITS(IB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PCE(PCE), .BrInstE(BrInstE), .BranchE(BranchE),
    .BranchTarget(BranchTarget), .HitF(HitF), .PredictF(PredictF),
    .PredictTarget(PredictTarget), .HitE(HitE)
  );

  always #5 clk = ~clk;

  // Reference: per set, a list of up to 2 entries ordered most-recently-updated first.
  int unsigned m_tag [SETS][2];
  logic [31:0] m_tgt [SETS][2];
  int          m_cnt [SETS][2];
  int          m_n   [SETS];

  function automatic int m_set(input logic [31:0] pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    int s;
    s = m_set(pc);
    for (int i = 0; i < m_n[s]; i++)
      if (m_tag[s][i] == m_tagof(pc)) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) m_n[s] = 0;
  endtask

  task automatic m_update(input logic [31:0] pc, input logic br, input logic tk,
                          input logic [31:0] tgt);
    int s, i, c;
    int unsigned t;
    logic [31:0] g;
    if (!br) return;
    s = m_set(pc);
    i = m_find(pc);
    if (i >= 0) begin
      t = m_tag[s][i]; g = m_tgt[s][i]; c = m_cnt[s][i];
      c = tk ? ((c + 1 > CMAX) ? CMAX : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
      if (tk) g = tgt;
      for (int j = i; j > 0; j--) begin
        m_tag[s][j] = m_tag[s][j-1]; m_tgt[s][j] = m_tgt[s][j-1]; m_cnt[s][j] = m_cnt[s][j-1];
      end
      m_tag[s][0] = t; m_tgt[s][0] = g; m_cnt[s][0] = c;
    end else if (tk) begin
      if (m_n[s] < 2) m_n[s]++;
      for (int j = m_n[s] - 1; j > 0; j--) begin
        m_tag[s][j] = m_tag[s][j-1]; m_tgt[s][j] = m_tgt[s][j-1]; m_cnt[s][j] = m_cnt[s][j-1];
      end
      m_tag[s][0] = m_tagof(pc); m_tgt[s][0] = tgt; m_cnt[s][0] = CINIT;
    end
  endtask

  task automatic m_expect(input logic [31:0] pc, output logic hit, output logic pred,
                          output logic [31:0] tgt);
    int i;
    i = m_find(pc);
    hit  = (i >= 0);
    pred = hit && (m_cnt[m_set(pc)][i] >= CINIT);
    tgt  = hit ? m_tgt[m_set(pc)][i] : 32'h0;
  endtask

  // Drive one E-stage transaction across the falling edge that commits it.
  task automatic do_update(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt);
    @(posedge clk); #1;
    PCE = pc; BrInstE = br; BranchE = tk; BranchTarget = tgt;
    @(negedge clk); #1;
    m_update(pc, br, tk, tgt);
    BrInstE = 1'b0; BranchE = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; #2;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic eh, ep;
    logic [31:0] et;
    apply_reset();
    PCF = 32'h40; PCE = 32'h40; #1;
    checks++;
    if ({HitF, PredictF, PredictTarget, HitE} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs got hit=%b pred=%b tgt=%h hite=%b want all 0",
               HitF, PredictF, PredictTarget, HitE);
    end
    m_expect(32'h40, eh, ep, et);
    checks++;
    if (HitF !== eh) begin
      errors++; $display("FAIL reset_model_hit got %b want %b", HitF, eh);
    end
  endtask

  task automatic test_alloc_basic();
    do_update(32'h40, 1'b1, 1'b1, 32'h100);
    PCF = 32'h40; PCE = 32'h40; #1;
    checks++;
    if ({HitF, PredictF, PredictTarget, HitE} !== {1'b1, 1'b1, 32'h100, 1'b1}) begin
      errors++;
      $display("FAIL alloc_basic got hit=%b pred=%b tgt=%h hite=%b want 1 1 00000100 1",
               HitF, PredictF, PredictTarget, HitE);
    end
  endtask

  task automatic test_counter_sat();
    logic eh, ep;
    logic [31:0] et;
    for (int k = 0; k < 7; k++) begin
      do_update(32'h40, 1'b1, (k >= 3), 32'h100 + 32'(k) * 4);
      PCF = 32'h40; #1;
      m_expect(32'h40, eh, ep, et);
      checks++;
      if ({HitF, PredictF, PredictTarget} !== {eh, ep, et}) begin
        errors++;
        $display("FAIL counter_step%0d got hit=%b pred=%b tgt=%h want %b %b %h",
                 k, HitF, PredictF, PredictTarget, eh, ep, et);
      end
    end
    // After 3 not-taken then 4 taken the counter sits at max: one not-taken keeps it predicting.
    do_update(32'h40, 1'b1, 1'b0, 32'hDEAD);
    PCF = 32'h40; #1;
    checks++;
    if ({HitF, PredictF, PredictTarget} !== {1'b1, 1'b1, 32'h118}) begin
      errors++;
      $display("FAIL counter_saturated got hit=%b pred=%b tgt=%h want 1 1 00000118",
               HitF, PredictF, PredictTarget);
    end
  endtask

  task automatic test_lru_evict();
    logic [31:0] pcs [3];
    logic [2:0] want;
    pcs[0] = 32'h40; pcs[1] = 32'h440; pcs[2] = 32'h840;
    want = 3'b101;
    apply_reset();
    do_update(32'h40, 1'b1, 1'b1, 32'h1000);
    do_update(32'h440, 1'b1, 1'b1, 32'h2000);
    do_update(32'h40, 1'b1, 1'b1, 32'h1004);
    do_update(32'h840, 1'b1, 1'b1, 32'h3000);
    for (int i = 0; i < 3; i++) begin
      PCF = pcs[i]; PCE = pcs[i]; #1;
      checks++;
      if (HitF !== want[i] || HitE !== want[i]) begin
        errors++;
        $display("FAIL lru_evict pc=%h got hit=%b hite=%b want %b", pcs[i], HitF, HitE, want[i]);
      end
    end
    PCF = 32'h843; #1;
    checks++;
    if ({HitF, PredictTarget} !== {1'b1, 32'h3000}) begin
      errors++;
      $display("FAIL low_bits_ignored got hit=%b tgt=%h want 1 00003000", HitF, PredictTarget);
    end
  endtask

  task automatic test_no_alloc();
    do_update(32'h80, 1'b1, 1'b0, 32'h500);
    do_update(32'hC0, 1'b0, 1'b1, 32'h600);
    PCF = 32'h80; PCE = 32'hC0; #1;
    checks++;
    if (HitF !== 1'b0 || HitE !== 1'b0) begin
      errors++; $display("FAIL no_alloc got hitf=%b hite=%b want 0 0", HitF, HitE);
    end
    PCF = 32'hC0; #1;
    checks++;
    if (HitF !== 1'b0) begin
      errors++; $display("FAIL brinst_low got hitf=%b want 0", HitF);
    end
  endtask

  task automatic test_same_set_timing();
    do_update(32'h1C0, 1'b1, 1'b1, 32'h200);
    @(posedge clk); #1;
    PCE = 32'h1C0; BrInstE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h300; PCF = 32'h1C0;
    #1;
    checks++;
    if ({HitF, PredictTarget, HitE} !== {1'b1, 32'h200, 1'b1}) begin
      errors++;
      $display("FAIL before_negedge got hit=%b tgt=%h hite=%b want 1 00000200 1",
               HitF, PredictTarget, HitE);
    end
    @(negedge clk); #1;
    m_update(32'h1C0, 1'b1, 1'b1, 32'h300);
    BrInstE = 1'b0; BranchE = 1'b0;
    checks++;
    if ({HitF, PredictF, PredictTarget} !== {1'b1, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL after_negedge got hit=%b pred=%b tgt=%h want 1 1 00000300",
               HitF, PredictF, PredictTarget);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, lk;
    logic br, tk, eh, ep;
    logic [31:0] et;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      pc = (32'($urandom_range(1, 3)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
      br = ($urandom_range(0, 3) != 0);
      tk = $urandom_range(0, 1) == 1;
      do_update(pc, br, tk, $urandom);
      lk = (32'($urandom_range(1, 3)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2);
      PCF = lk; PCE = pc; #1;
      m_expect(lk, eh, ep, et);
      checks++;
      if ({HitF, PredictF, PredictTarget} !== {eh, ep, et}) begin
        errors++;
        $display("FAIL random_lookup n=%0d pc=%h got %b %b %h want %b %b %h",
                 n, lk, HitF, PredictF, PredictTarget, eh, ep, et);
      end
      checks++;
      if (HitE !== (m_find(pc) >= 0)) begin
        errors++;
        $display("FAIL random_hite n=%0d pc=%h got %b want %b", n, pc, HitE, m_find(pc) >= 0);
      end
    end
  endtask

  task automatic test_async_reset();
    logic eh, ep;
    logic [31:0] et;
    do_update(32'h40, 1'b1, 1'b1, 32'h700);
    @(posedge clk); #1;
    PCE = 32'h40; BrInstE = 1'b1; BranchE = 1'b1; BranchTarget = 32'h900; PCF = 32'h40;
    #1 rst = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({HitF, PredictF, PredictTarget, HitE} !== 35'h0) begin
      errors++;
      $display("FAIL async_reset got hit=%b pred=%b tgt=%h hite=%b want all 0",
               HitF, PredictF, PredictTarget, HitE);
    end
    @(negedge clk); #1;
    BrInstE = 1'b0; BranchE = 1'b0;
    rst = 1'b0;
    #1;
    m_expect(32'h40, eh, ep, et);
    checks++;
    if ({HitF, PredictF, PredictTarget, HitE} !== {eh, ep, et, 1'b0}) begin
      errors++;
      $display("FAIL reset_wins got hit=%b pred=%b tgt=%h hite=%b want %b %b %h 0",
               HitF, PredictF, PredictTarget, HitE, eh, ep, et);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_alloc_basic();
    test_counter_sat();
    test_lru_evict();
    test_no_alloc();
    test_same_set_timing();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
